// File: rtl/shift_delay_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shift_delay_ctrl
//  Purpose  : Sequencer for a variable-tap shift-register delay line. Issues
//             shift enables and the active tap count, tracks how many samples
//             have entered the line since the last flush/reset, and raises an
//             output-valid that lines up with the delayed tap output. Applies
//             valid/ready backpressure on both sides. No data passes through.
//  Ports    : i_clk/i_rst        clock, synchronous active-high reset
//             i_enable           0 parks the sequencer in IDLE (fill kept)
//             i_flush            discard line contents (fill -> 0)
//             i_cfg_*/o_cfg_*    tap-count reconfiguration handshake + error
//             i_in_valid/o_in_ready   sample source handshake
//             o_shift_en/o_shift_taps drive the delay line
//             o_out_valid/i_out_ready consumer handshake
//             o_fill             shifts since flush/reset, saturating
//  Revision : 1.0  initial release
// ============================================================================
module shift_delay_ctrl #(
    parameter int DEEP_BIT     = 4,
    parameter int DEFAULT_TAPS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic                i_flush,
    input  logic                i_cfg_valid,
    input  logic [DEEP_BIT-1:0] i_cfg_taps,
    output logic                o_cfg_ready,
    output logic                o_cfg_err,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    output logic                o_shift_en,
    output logic [DEEP_BIT-1:0] o_shift_taps,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [DEEP_BIT-1:0] o_fill
);

    localparam logic [DEEP_BIT-1:0] c_default_taps = DEEP_BIT'(DEFAULT_TAPS);
    localparam logic [DEEP_BIT-1:0] c_fill_max     = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [DEEP_BIT-1:0] r_taps;
    logic [DEEP_BIT-1:0] w_taps_next;
    logic [DEEP_BIT-1:0] r_fill;
    logic [DEEP_BIT-1:0] w_fill_next;
    logic                r_out_valid;
    logic                w_out_valid_next;
    logic                r_cfg_err;
    logic                w_cfg_err_next;

    logic                w_cfg_ready;
    logic                w_cfg_acc;
    logic                w_in_ready;
    logic                w_shift;

    // Retuning is only allowed while no delayed sample is waiting, so the
    // tap count can never change under a sample that is being presented.
    assign w_cfg_ready = ~i_rst & ~i_flush & ~r_out_valid;
    assign w_cfg_acc   = i_cfg_valid & w_cfg_ready;

    // Reset and flush both win over a shift; a config accept also takes the
    // cycle. A pending output must drain (or drain this cycle) before the
    // line advances, otherwise the presented tap value would be overwritten.
    assign w_in_ready  = ~i_rst & i_enable & (r_state != S_IDLE) & ~i_flush
                       & ~w_cfg_acc & (~r_out_valid | i_out_ready);
    assign w_shift     = i_in_valid & w_in_ready;

    always_comb begin
        w_taps_next      = r_taps;
        w_fill_next      = r_fill;
        w_out_valid_next = r_out_valid;
        w_cfg_err_next   = 1'b0;
        w_state_next     = r_state;

        if (i_flush) begin
            w_fill_next      = '0;
            w_out_valid_next = 1'b0;
        end else begin
            if (w_cfg_acc) begin
                if (i_cfg_taps != '0) begin
                    w_taps_next = i_cfg_taps;
                end else begin
                    w_cfg_err_next = 1'b1;
                end
            end

            if (w_shift && (r_fill != c_fill_max)) begin
                w_fill_next = r_fill + 1'b1;
            end

            // Once taps samples are in, every shift puts a fresh delayed
            // sample on the tap; otherwise a consumed sample is retired.
            if (w_shift && (w_fill_next >= w_taps_next)) begin
                w_out_valid_next = 1'b1;
            end else if (i_out_ready) begin
                w_out_valid_next = 1'b0;
            end
        end

        // FILL/RUN simply reflect whether the line already holds taps
        // samples after this cycle's updates (flush, retune, shift).
        if (!i_enable) begin
            w_state_next = S_IDLE;
        end else if (w_fill_next >= w_taps_next) begin
            w_state_next = S_RUN;
        end else begin
            w_state_next = S_FILL;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_taps      <= c_default_taps;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_taps      <= w_taps_next;
            r_fill      <= w_fill_next;
            r_out_valid <= w_out_valid_next;
            r_cfg_err   <= w_cfg_err_next;
        end
    end

    assign o_cfg_ready  = w_cfg_ready;
    assign o_cfg_err    = r_cfg_err;
    assign o_in_ready   = w_in_ready;
    assign o_shift_en   = w_shift;
    assign o_shift_taps = r_taps;
    assign o_out_valid  = r_out_valid;
    assign o_fill       = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_shift_delay_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_delay_ctrl
//  Purpose  : Self-checking bench for shift_delay_ctrl. A delay-line emulation
//             carries sample tags; a reference model predicts handshakes and
//             queues the tag each consumer transfer must deliver.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_delay_ctrl;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       flush;
    logic       cfg_valid;
    logic [3:0] cfg_taps;
    logic       cfg_ready;
    logic       cfg_err;
    logic       in_valid;
    logic       in_ready;
    logic       shift_en;
    logic [3:0] shift_taps;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] fill;
    int         din;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int  m_fill;
    int  m_taps;
    bit  m_ov;
    bit  m_err;
    bit  m_active;
    int  acc[$];   // every sample accepted, in order
    int  sb[$];    // tags the consumer must still receive

    int  line_q[16];

    shift_delay_ctrl #(.DEEP_BIT(4), .DEFAULT_TAPS(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_enable     (enable),
        .i_flush      (flush),
        .i_cfg_valid  (cfg_valid),
        .i_cfg_taps   (cfg_taps),
        .o_cfg_ready  (cfg_ready),
        .o_cfg_err    (cfg_err),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .o_shift_en   (shift_en),
        .o_shift_taps (shift_taps),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_fill       (fill)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Physical delay line carrying sample tags.
    always @(posedge clk) begin
        if (shift_en === 1'b1) begin
            line_q[0] <= din;
            for (int k = 1; k < 16; k++) line_q[k] <= line_q[k-1];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every consumer transfer must deliver the oldest queued tag.
    always @(negedge clk) begin
        int idx;
        int exp;
        #2;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: got a transfer expected none at %0t", $time);
            end else begin
                exp = sb.pop_front();
                idx = int'(shift_taps) - 1;
                if (idx < 0) idx = 0;
                chk("out_data", line_q[idx], exp);
            end
        end
    end

    task automatic step(input bit r, input bit fl, input bit en, input bit cv,
                        input logic [3:0] ct, input bit iv, input bit ordy,
                        input bit chk_on);
        bit e_cfg_ready;
        bit e_in_ready;
        bit e_shift;
        bit cacc;
        @(negedge clk);
        rst = r; flush = fl; enable = en; cfg_valid = cv; cfg_taps = ct;
        in_valid = iv; out_ready = ordy; din = int'($urandom_range(1, 1000000));
        #3;
        e_cfg_ready = !r && !fl && !m_ov;
        e_in_ready  = !r && en && m_active && !fl && !(cv && e_cfg_ready) && (!m_ov || ordy);
        e_shift     = iv && e_in_ready;
        if (chk_on) begin
            chk("fill",       int'(fill),       m_fill);
            chk("shift_taps", int'(shift_taps), m_taps);
            chk("out_valid",  int'(out_valid),  int'(m_ov));
            chk("cfg_err",    int'(cfg_err),    int'(m_err));
            chk("cfg_ready",  int'(cfg_ready),  int'(e_cfg_ready));
            chk("in_ready",   int'(in_ready),   int'(e_in_ready));
            chk("shift_en",   int'(shift_en),   int'(e_shift));
        end
        if (r) begin
            m_fill = 0; m_taps = 8; m_ov = 0; m_err = 0; m_active = 0;
            sb.delete();
        end else begin
            cacc  = cv && e_cfg_ready;
            m_err = cacc && (ct == 4'd0);
            if (fl) begin
                m_fill = 0; m_ov = 0;
                sb.delete();
            end else begin
                if (cacc && ct != 4'd0) m_taps = int'(ct);
                if (e_shift) begin
                    acc.push_back(din);
                    if (m_fill < 15) m_fill++;
                end
                // Output tag: the sample accepted taps shifts ago (inclusive).
                if (e_shift && m_fill >= m_taps) begin
                    m_ov = 1;
                    sb.push_back(acc[acc.size() - m_taps]);
                end else if (ordy) begin
                    m_ov = 0;
                end
            end
            m_active = en;
        end
    endtask

    // shorthands: run n cycles of plain traffic
    task automatic run(input int n, input bit iv, input bit ordy);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0, 4'd0, iv, ordy, 1);
    endtask

    task automatic cfg(input logic [3:0] t, input bit iv);
        step(0, 0, 1, 1, t, iv, 0, 1);
    endtask

    initial begin
        rst = 1; enable = 0; flush = 0; cfg_valid = 0; cfg_taps = 0;
        in_valid = 0; out_ready = 0; din = 0;
        step(1, 0, 0, 0, 4'd0, 0, 0, 0);
        step(1, 0, 0, 0, 4'd0, 1, 1, 1);        // reset state
        // priming with taps=8, then drain the held output
        run(1, 0, 0);
        run(8, 1, 0);
        run(2, 0, 0);
        run(1, 0, 1);
        // continuous throughput
        run(20, 1, 1);
        // consumer stall, then release
        run(4, 1, 0);
        run(6, 1, 1);
        // retune: fill 10 then taps=4 straight to RUN
        step(0, 1, 1, 0, 4'd0, 1, 1, 1);
        cfg(4'd15, 0);
        run(10, 1, 1);
        cfg(4'd4, 1);
        run(3, 1, 1);
        // retune upward: fill 10, taps=12 needs two more shifts
        step(0, 1, 1, 0, 4'd0, 0, 1, 1);
        cfg(4'd15, 0);
        run(10, 1, 1);
        cfg(4'd12, 0);
        run(4, 1, 1);
        // zero taps rejected; config blocked while output pending
        run(1, 0, 1);
        cfg(4'd0, 0);
        run(2, 1, 0);
        cfg(4'd3, 1);
        run(2, 0, 1);
        // flush and reset mid-stream with a sample offered
        run(12, 1, 1);
        step(0, 1, 1, 0, 4'd0, 1, 1, 1);
        run(10, 1, 1);
        step(1, 0, 1, 0, 4'd0, 1, 1, 1);
        run(12, 1, 1);
        // disable holds a pending output until consumed
        run(1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 4'd0, 1, 0, 1);
        run(4, 1, 1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 24) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 7),
                 1);
        end
        step(0, 0, 1, 0, 4'd0, 0, 0, 1);
        #4;
        chk("sb_drain", sb.size(), m_ov ? 1 : 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
